ap_cam_array: RTL

- Parametrised multi-row CAM array for the associative processor. Successor to the single-row masked-write/masked-match cell.
- Holds ROWS words of WORD_WIDTH bits and keeps one tag bit per row.
- Executes compare, tag-combine, tagged parallel write and direct read/write commands through a valid/ready command port and a response port.
- Sits between the AP microsequencer (command source) and the result/reduction logic (consumes tags and responses).

---
 rtl/ap_pkg.sv | 22 ++
 rtl/ap_cam_array_if.sv | 32 +++
 rtl/ap_prio_enc.sv | 20 ++
 rtl/ap_cam_array.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/ap_pkg.sv
// Shared opcode and FSM state definitions for the associative-processor CAM array.
package ap_pkg;

  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_WRITE     = 3'd1,
    OP_READ      = 3'd2,
    OP_CMP_SET   = 3'd3,
    OP_CMP_AND   = 3'd4,
    OP_CMP_OR    = 3'd5,
    OP_TAG_WRITE = 3'd6,
    OP_CLR_TAGS  = 3'd7
  } ap_op_e;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } ap_state_e;

endpackage

// File: rtl/ap_cam_array_if.sv
// Command/response bundle between the AP microsequencer and the CAM array.
interface ap_cam_array_if #(
  parameter int WORD_WIDTH = 8,
  parameter int ROWS       = 16
) ();
  localparam int ADDR_BITS = $clog2(ROWS);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic [ADDR_BITS-1:0]  cmd_addr;
  logic [WORD_WIDTH-1:0] cmd_key;
  logic [WORD_WIDTH-1:0] cmd_mask;
  logic [WORD_WIDTH-1:0] cmd_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WORD_WIDTH-1:0] rsp_data;
  logic                  rsp_err;
  logic [ROWS-1:0]       tags;
  logic                  match_any;
  logic [ADDR_BITS-1:0]  match_idx;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_key, cmd_mask, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, tags, match_any, match_idx
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_key, cmd_mask, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, tags, match_any, match_idx
  );
endinterface

// File: rtl/ap_prio_enc.sv
// Lowest-index-first priority encoder with an any-set flag.
module ap_prio_enc #(
  parameter  int ROWS      = 16,
  localparam int ADDR_BITS = $clog2(ROWS)
) (
  input  logic [ROWS-1:0]      req,
  output logic                 any,
  output logic [ADDR_BITS-1:0] idx
);

  always_comb begin
    any = |req;
    idx = '0;
    // Scan downward so the lowest set index is the last one written.
    for (int unsigned i = ROWS; i > 0; i--) begin
      if (req[i-1]) idx = ADDR_BITS'(i - 1);
    end
  end

endmodule

// File: rtl/ap_cam_array.sv
// Multi-row masked CAM with a per-row tag bit, driven by a valid/ready command port
// and a held response port; the INIT sweep zeroes every row after reset.
module ap_cam_array
  import ap_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int ROWS       = 16
) (
  input logic           clka,
  input logic           rst,
  ap_cam_array_if.slave bus
);

  localparam int ADDR_BITS = $clog2(ROWS);
  localparam logic [ADDR_BITS-1:0] LAST_ROW = ADDR_BITS'(ROWS - 1);

  typedef logic [WORD_WIDTH-1:0] word_t;

  ap_state_e            state;
  logic [ADDR_BITS-1:0] clr_cnt;

  ap_op_e               op_q;
  logic [ADDR_BITS-1:0] addr_q;
  word_t                key_q;
  word_t                mask_q;
  word_t                data_q;

  word_t                mem [ROWS];
  logic  [ROWS-1:0]     tags_q;
  logic  [ROWS-1:0]     match_vec;
  logic  [ROWS-1:0]     tags_nxt;
  logic  [ROWS-1:0]     wr_en;
  word_t                row_new [ROWS];

  logic                 addr_ok;
  word_t                rd_word;
  logic                 nxt_any;
  logic [ADDR_BITS-1:0] nxt_idx;

  // Zero-extended so the range check stays meaningful for non-power-of-2 ROWS.
  assign addr_ok = 32'(addr_q) < ROWS;
  assign rd_word = addr_ok ? mem[addr_q] : '0;
  assign bus.tags = tags_q;

  always_comb begin
    for (int unsigned i = 0; i < ROWS; i++) begin
      match_vec[i] = ((mem[i] ^ key_q) & mask_q) == '0;
      row_new[i]   = (data_q & mask_q) | (mem[i] & ~mask_q);
    end
  end

  always_comb begin
    tags_nxt = tags_q;
    unique case (op_q)
      OP_CMP_SET:  tags_nxt = match_vec;
      OP_CMP_AND:  tags_nxt = tags_q & match_vec;
      OP_CMP_OR:   tags_nxt = tags_q | match_vec;
      OP_CLR_TAGS: tags_nxt = '0;
      default:     tags_nxt = tags_q;
    endcase
  end

  always_comb begin
    wr_en = '0;
    if (!rst) begin
      if (state == ST_INIT) begin
        wr_en[clr_cnt] = 1'b1;
      end else if (state == ST_EXEC) begin
        if (op_q == OP_WRITE && addr_ok) wr_en[addr_q] = 1'b1;
        else if (op_q == OP_TAG_WRITE)   wr_en = tags_q;
      end
    end
  end

  ap_prio_enc #(.ROWS(ROWS)) u_prio (
    .req (tags_nxt),
    .any (nxt_any),
    .idx (nxt_idx)
  );

  // Storage has no reset; the INIT sweep is what clears it.
  always_ff @(posedge clka) begin
    for (int unsigned i = 0; i < ROWS; i++) begin
      if (wr_en[i]) mem[i] <= (state == ST_INIT) ? '0 : row_new[i];
    end
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      state         <= ST_INIT;
      clr_cnt       <= '0;
      tags_q        <= '0;
      op_q          <= OP_NOP;
      addr_q        <= '0;
      key_q         <= '0;
      mask_q        <= '0;
      data_q        <= '0;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
      bus.match_any <= 1'b0;
      bus.match_idx <= '0;
    end else begin
      unique case (state)
        ST_INIT: begin
          if (clr_cnt == LAST_ROW) begin
            clr_cnt       <= '0;
            state         <= ST_IDLE;
            bus.cmd_ready <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            op_q          <= ap_op_e'(bus.cmd_op);
            addr_q        <= bus.cmd_addr;
            key_q         <= bus.cmd_key;
            mask_q        <= bus.cmd_mask;
            data_q        <= bus.cmd_data;
            bus.cmd_ready <= 1'b0;
            state         <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          tags_q        <= tags_nxt;
          bus.match_any <= nxt_any;
          bus.match_idx <= nxt_idx;
          bus.rsp_data  <= (op_q == OP_READ) ? rd_word : '0;
          bus.rsp_err   <= (op_q == OP_WRITE || op_q == OP_READ) && !addr_ok;
          bus.rsp_valid <= 1'b1;
          state         <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule
